// File: rtl/instruction_decoder_if.sv
// Decode-stage bus: program-memory fetch data and ALU zero in, decoded
// data-path and sequencer controls out.
interface instruction_decoder_if;
    logic [7:0] pm_data;
    logic       r_eq_0;
    logic [7:0] ir;
    logic       jmp;
    logic       jmp_nz;
    logic [3:0] jmp_addr;
    logic       dont_jmp;
    logic [8:0] reg_en;
    logic [3:0] source_sel;
    logic       x_sel;
    logic       y_sel;
    logic [2:0] alu_func;
    logic [7:0] from_ID;

    // decoder side
    modport master (
        input  pm_data,
        input  r_eq_0,
        output ir,
        output jmp,
        output jmp_nz,
        output jmp_addr,
        output dont_jmp,
        output reg_en,
        output source_sel,
        output x_sel,
        output y_sel,
        output alu_func,
        output from_ID
    );

    // sequencer / data-path / memory side
    modport slave (
        output pm_data,
        output r_eq_0,
        input  ir,
        input  jmp,
        input  jmp_nz,
        input  jmp_addr,
        input  dont_jmp,
        input  reg_en,
        input  source_sel,
        input  x_sel,
        input  y_sel,
        input  alu_func,
        input  from_ID
    );
endinterface

// File: rtl/instruction_decoder.sv
// Decode stage of the 8-bit processor: instruction register, combinational
// control decode, zero flag and a saturating retired-instruction counter.
module instruction_decoder #(
    parameter logic [7:0] ALIGN_OP = 8'hD8,
    parameter int         CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  sync_reset,
    instruction_decoder_if.master bus
);

    logic [7:0]       ir_q;
    logic             z_q;
    logic [CNT_W-1:0] instr_count;
    logic [7:0]       count_lo;

    logic             is_load;
    logic             is_move;
    logic             is_alu;
    logic             is_jmp;
    logic             is_jnz;

    logic [8:0]       reg_en_d;
    logic [3:0]       source_sel_d;
    logic             x_sel_d;
    logic             y_sel_d;
    logic [2:0]       alu_func_d;
    logic             jmp_d;
    logic             jmp_nz_d;
    logic [3:0]       jmp_addr_d;

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            ir_q <= 8'h00;
        end else begin
            ir_q <= bus.pm_data;
        end
    end

    assign is_load = (ir_q[7] == 1'b0);
    assign is_move = (ir_q[7:6] == 2'b10);
    assign is_alu  = (ir_q[7:5] == 3'b110) && (ir_q != ALIGN_OP);
    assign is_jmp  = (ir_q[7:4] == 4'hE);
    assign is_jnz  = (ir_q[7:4] == 4'hF);

    // The flag only follows real ALU results; align shares the ALU opcode
    // space but must leave the flag untouched.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            z_q <= 1'b0;
        end else if (is_alu) begin
            z_q <= bus.r_eq_0;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            instr_count <= '0;
        end else if (instr_count != {CNT_W{1'b1}}) begin
            instr_count <= instr_count + 1'b1;
        end
    end

    generate
        if (CNT_W >= 8) begin : g_cnt_wide
            assign count_lo = instr_count[7:0];
        end else begin : g_cnt_narrow
            assign count_lo = {{(8 - CNT_W){1'b0}}, instr_count};
        end
    endgenerate

    always_comb begin
        reg_en_d     = 9'h000;
        source_sel_d = 4'd0;
        x_sel_d      = 1'b0;
        y_sel_d      = 1'b0;
        alu_func_d   = 3'd0;
        jmp_d        = 1'b0;
        jmp_nz_d     = 1'b0;
        jmp_addr_d   = 4'd0;
        if (!sync_reset) begin
            if (is_load) begin
                reg_en_d     = 9'h001 << ir_q[6:4];
                source_sel_d = 4'd8;
            end else if (is_move) begin
                reg_en_d = 9'h001 << ir_q[5:3];
                // dst == src is the encoding for "move ALU result r"
                if (ir_q[5:3] == ir_q[2:0]) begin
                    source_sel_d = 4'd9;
                end else begin
                    source_sel_d = {1'b0, ir_q[2:0]};
                end
            end else if (is_alu) begin
                reg_en_d   = 9'h100;
                x_sel_d    = ir_q[4];
                y_sel_d    = ir_q[3];
                alu_func_d = ir_q[2:0];
            end else if (is_jmp) begin
                jmp_d      = 1'b1;
                jmp_addr_d = ir_q[3:0];
            end else if (is_jnz) begin
                jmp_nz_d   = 1'b1;
                jmp_addr_d = ir_q[3:0];
            end
        end
    end

    assign bus.ir         = ir_q;
    assign bus.dont_jmp   = z_q;
    assign bus.reg_en     = reg_en_d;
    assign bus.source_sel = source_sel_d;
    assign bus.x_sel      = x_sel_d;
    assign bus.y_sel      = y_sel_d;
    assign bus.alu_func   = alu_func_d;
    assign bus.jmp        = jmp_d;
    assign bus.jmp_nz     = jmp_nz_d;
    assign bus.jmp_addr   = jmp_addr_d;
    assign bus.from_ID    = sync_reset ? 8'h00 : count_lo;

    a_jmp_exclusive : assert property (@(posedge clk) !(jmp_d && jmp_nz_d));
    a_reset_quiet   : assert property (@(posedge clk) sync_reset |-> (reg_en_d == 9'h000));

endmodule

// File: tb/tb_instruction_decoder.sv
// Self-checking bench for instruction_decoder: directed scenarios plus a
// randomized run against an opcode-class reference model.
module tb_instruction_decoder;

    typedef struct packed {
        logic [8:0] reg_en;
        logic [3:0] src;
        logic       x;
        logic       y;
        logic [2:0] alu;
        logic       jmp;
        logic       jnz;
        logic [3:0] addr;
    } ctl_t;

    logic clk;
    logic sync_reset;
    int   checks;
    int   errors;

    int   m_ir;
    bit   m_z;
    int   m_cnt;

    instruction_decoder_if bus ();

    instruction_decoder #(
        .ALIGN_OP (8'hD8),
        .CNT_W    (8)
    ) dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected controls from the instruction classes, by opcode value range.
    function automatic ctl_t model_ctl(input int i, input bit rst);
        ctl_t c;
        int   d;
        int   s;
        c = '0;
        if (rst) return c;
        if (i < 128) begin
            c.reg_en = 9'(1 << (i / 16));
            c.src    = 4'd8;
        end else if (i < 192) begin
            d        = (i / 8) % 8;
            s        = i % 8;
            c.reg_en = 9'(1 << d);
            c.src    = (d == s) ? 4'd9 : 4'(s);
        end else if (i < 224) begin
            if (i != 216) begin
                c.reg_en = 9'h100;
                c.x      = 1'((i / 16) % 2);
                c.y      = 1'((i / 8) % 2);
                c.alu    = 3'(i % 8);
            end
        end else if (i < 240) begin
            c.jmp  = 1'b1;
            c.addr = 4'(i % 16);
        end else begin
            c.jnz  = 1'b1;
            c.addr = 4'(i % 16);
        end
        return c;
    endfunction

    task automatic tick();
        if (sync_reset) begin
            m_ir  = 0;
            m_z   = 1'b0;
            m_cnt = 0;
        end else begin
            if (m_ir >= 192 && m_ir < 224 && m_ir != 216) m_z = bus.r_eq_0;
            m_ir = int'(bus.pm_data);
            if (m_cnt < 255) m_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        sync_reset  = 1'b1;
        bus.pm_data = 8'hE5;
        bus.r_eq_0  = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.jmp !== 1'b0) begin
            errors++; $display("FAIL reset_jmp: got %0b want 0", bus.jmp);
        end
        checks++;
        if (bus.ir !== 8'h00) begin
            errors++; $display("FAIL reset_ir: got %h want 00", bus.ir);
        end
        checks++;
        if (bus.dont_jmp !== 1'b0) begin
            errors++; $display("FAIL reset_dont_jmp: got %0b want 0", bus.dont_jmp);
        end
        checks++;
        if (bus.from_ID !== 8'h00) begin
            errors++; $display("FAIL reset_from_id: got %h want 00", bus.from_ID);
        end
        sync_reset = 1'b0;
        tick();
        checks++;
        if (bus.ir !== 8'hE5 || bus.jmp !== 1'b1 || bus.jmp_addr !== 4'h5) begin
            errors++;
            $display("FAIL release_jump: got ir=%h jmp=%0b addr=%h want ir=e5 jmp=1 addr=5",
                     bus.ir, bus.jmp, bus.jmp_addr);
        end
    endtask

    task automatic test_load_move();
        bus.pm_data = 8'h3A;
        tick();
        checks++;
        if (bus.reg_en !== 9'h008 || bus.source_sel !== 4'd8) begin
            errors++;
            $display("FAIL load_3a: got reg_en=%h src=%0d want 008/8", bus.reg_en, bus.source_sel);
        end
        bus.pm_data = 8'h8A;
        tick();
        checks++;
        if (bus.reg_en !== 9'h002 || bus.source_sel !== 4'd2) begin
            errors++;
            $display("FAIL move_8a: got reg_en=%h src=%0d want 002/2", bus.reg_en, bus.source_sel);
        end
        bus.pm_data = 8'h9B;
        tick();
        checks++;
        if (bus.reg_en !== 9'h008 || bus.source_sel !== 4'd9) begin
            errors++;
            $display("FAIL move_r_9b: got reg_en=%h src=%0d want 008/9", bus.reg_en, bus.source_sel);
        end
    endtask

    task automatic test_flag_branch();
        for (int k = 0; k < 2; k++) begin
            bit want_z;
            want_z      = (k == 0);
            bus.pm_data = 8'hC3;
            tick();
            checks++;
            if (bus.reg_en !== 9'h100 || bus.x_sel !== 1'b0 || bus.y_sel !== 1'b0
                || bus.alu_func !== 3'd3) begin
                errors++;
                $display("FAIL alu_c3: got reg_en=%h x=%0b y=%0b f=%0d want 100/0/0/3",
                         bus.reg_en, bus.x_sel, bus.y_sel, bus.alu_func);
            end
            bus.r_eq_0  = want_z;
            bus.pm_data = 8'hF7;
            tick();
            bus.r_eq_0 = 1'b0;
            checks++;
            if (bus.jmp_nz !== 1'b1 || bus.jmp !== 1'b0 || bus.jmp_addr !== 4'h7
                || bus.dont_jmp !== want_z) begin
                errors++;
                $display("FAIL jnz_after_alu%0d: got jnz=%0b jmp=%0b addr=%h z=%0b want 1/0/7/%0b",
                         k, bus.jmp_nz, bus.jmp, bus.jmp_addr, bus.dont_jmp, want_z);
            end
        end
    endtask

    task automatic test_align();
        bus.pm_data = 8'hC3;
        tick();
        bus.r_eq_0  = 1'b1;
        bus.pm_data = 8'hD8;
        tick();
        bus.r_eq_0 = 1'b0;
        checks++;
        if (bus.reg_en !== 9'h000 || bus.jmp !== 1'b0 || bus.jmp_nz !== 1'b0
            || bus.alu_func !== 3'd0 || bus.x_sel !== 1'b0 || bus.y_sel !== 1'b0) begin
            errors++;
            $display("FAIL align_decode: got reg_en=%h jmp=%0b jnz=%0b f=%0d x=%0b y=%0b want all 0",
                     bus.reg_en, bus.jmp, bus.jmp_nz, bus.alu_func, bus.x_sel, bus.y_sel);
        end
        bus.pm_data = 8'h00;
        tick();
        checks++;
        if (bus.dont_jmp !== 1'b1) begin
            errors++; $display("FAIL align_keeps_flag: got z=%0b want 1", bus.dont_jmp);
        end
    endtask

    task automatic test_mid_reset();
        bus.pm_data = 8'hC5;
        tick();
        bus.r_eq_0 = 1'b1;
        tick();
        bus.r_eq_0 = 1'b0;
        sync_reset = 1'b1;
        #1;
        checks++;
        if (bus.ir !== 8'hC5 || bus.reg_en !== 9'h000 || bus.alu_func !== 3'd0
            || bus.dont_jmp !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_comb: got ir=%h reg_en=%h f=%0d z=%0b want c5/000/0/1",
                     bus.ir, bus.reg_en, bus.alu_func, bus.dont_jmp);
        end
        tick();
        checks++;
        if (bus.dont_jmp !== 1'b0 || bus.from_ID !== 8'h00 || bus.ir !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_edge: got z=%0b cnt=%h ir=%h want 0/00/00",
                     bus.dont_jmp, bus.from_ID, bus.ir);
        end
        sync_reset  = 1'b0;
        bus.pm_data = 8'h3A;
        tick();
        checks++;
        if (bus.reg_en !== 9'h008 || bus.source_sel !== 4'd8 || bus.from_ID !== 8'h01) begin
            errors++;
            $display("FAIL post_reset_fetch: got reg_en=%h src=%0d cnt=%h want 008/8/01",
                     bus.reg_en, bus.source_sel, bus.from_ID);
        end
    endtask

    task automatic test_random();
        ctl_t exp;
        ctl_t got;
        for (int n = 0; n < 500; n++) begin
            sync_reset  = ($urandom_range(0, 39) == 0);
            bus.pm_data = 8'($urandom);
            tick();
            bus.r_eq_0 = 1'($urandom);
            exp = model_ctl(m_ir, sync_reset);
            got = '{bus.reg_en, bus.source_sel, bus.x_sel, bus.y_sel, bus.alu_func,
                    bus.jmp, bus.jmp_nz, bus.jmp_addr};
            checks++;
            if (got !== exp || bus.ir !== 8'(m_ir) || bus.dont_jmp !== m_z
                || bus.from_ID !== (sync_reset ? 8'h00 : 8'(m_cnt))) begin
                errors++;
                $display("FAIL random_%0d: ir=%h got ctl=%h z=%0b cnt=%h want ir=%h ctl=%h z=%0b cnt=%h",
                         n, bus.ir, got, bus.dont_jmp, bus.from_ID, 8'(m_ir), exp, m_z,
                         sync_reset ? 8'h00 : 8'(m_cnt));
            end
        end
        sync_reset = 1'b0;
    endtask

    task automatic test_saturation();
        sync_reset = 1'b1;
        tick();
        sync_reset = 1'b0;
        for (int n = 1; n <= 300; n++) begin
            bus.pm_data = 8'($urandom);
            tick();
            if (n == 254 || n == 255 || n == 256 || n == 300) begin
                checks++;
                if (bus.from_ID !== ((n < 255) ? 8'(n) : 8'hFF)) begin
                    errors++;
                    $display("FAIL count_%0d: got %h want %h", n, bus.from_ID,
                             (n < 255) ? 8'(n) : 8'hFF);
                end
            end
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        m_ir        = 0;
        m_z         = 1'b0;
        m_cnt       = 0;
        sync_reset  = 1'b1;
        bus.pm_data = 8'h00;
        bus.r_eq_0  = 1'b0;
        test_reset();
        test_load_move();
        test_flag_branch();
        test_align();
        test_mid_reset();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_decoder.md
Name: instruction_decoder

Overview:
- Decode stage of the 8-bit microprocessor; the counterpart of the program sequencer.
- Captures the program-memory word addressed by the sequencer's pm_addr into the instruction register (ir).
- Decodes ir into data-path controls and into the jump controls (jmp, jmp_nz, jmp_addr, dont_jmp) consumed by the sequencer.
- Owns the zero flag and a retired-instruction counter for debug observation.

Parameters:
- ALIGN_OP, 8'hD8, opcode of the align instruction; it is decoded as a no-op with no flag update (the sequencer performs the address jump).
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- sync_reset  input  1  reset; synchronous, active-high
- pm_data  input  8  program-memory read data for the current pm_addr
- r_eq_0  input  1  ALU result-is-zero, valid in the cycle an ALU instruction sits in ir
- ir  output  8  instruction register
- jmp  output  1  unconditional jump request
- jmp_nz  output  1  conditional (jump-if-not-zero) request
- jmp_addr  output  4  jump target (page number)
- dont_jmp  output  1  zero flag; when 1 the sequencer suppresses jmp_nz
- reg_en  output  9  load enables: [0]x0 [1]x1 [2]y0 [3]y1 [4]o_reg [5]m [6]i [7]dm [8]r
- source_sel  output  4  data-bus source: 0-7 = register index, 8 = immediate ir[3:0], 9 = ALU r
- x_sel  output  1  ALU x operand select
- y_sel  output  1  ALU y operand select
- alu_func  output  3  ALU function
- from_ID  output  8  debug: instr_count[7:0]

Behaviour:
- ir: rising edge, ir <= pm_data. While sync_reset=1, ir <= 8'h00. Reset value 8'h00.
- Decoding is combinational from ir. While sync_reset=1, force every output to 0 except ir and dont_jmp. This includes reg_en, jmp, jmp_nz, jmp_addr, source_sel, x_sel, y_sel and alu_func.
- Load, ir[7]=0:
  - reg_en[ir[6:4]]=1; source_sel=8.
- Move, ir[7:6]=2'b10:
  - reg_en[ir[5:3]]=1.
  - source_sel={1'b0,ir[2:0]}, except when ir[5:3]==ir[2:0]: source_sel=9 (move r into the destination).
- ALU, ir[7:5]=3'b110 and ir!=ALIGN_OP:
  - reg_en[8]=1; x_sel=ir[4]; y_sel=ir[3]; alu_func=ir[2:0].
- ir==ALIGN_OP:
  - All reg_en=0; jmp=0; jmp_nz=0; no flag update.
  - Outputs x_sel, y_sel and alu_func are 0.
- Jump, ir[7:4]=4'hE:
  - jmp=1; jmp_addr=ir[3:0].
- Conditional jump, ir[7:4]=4'hF:
  - jmp_nz=1; jmp_addr=ir[3:0].
- All outputs not set by the decoded instruction are 0. jmp and jmp_nz are never both 1.
- Zero flag z:
  - Rising edge: if sync_reset, z <= 0.
  - Otherwise, if ir is a non-align ALU instruction, z <= r_eq_0.
  - Otherwise z holds.
  - dont_jmp = z, so one cycle after the ALU instruction retires.
- ALU immediately followed by jnz: the jnz sees the flag from that ALU instruction.
- instr_count:
  - Reset 0. Increments by 1 on each clock edge with sync_reset=0.
  - Saturates at all-ones (2^CNT_W-1); it does not wrap.
- Latency:
  - pm_data to ir: 1 cycle.
  - ir to controls: combinational, same cycle.
  - ALU result to dont_jmp: 1 cycle.
- Reset mid-program:
  - The cycle sync_reset rises, all decoded controls drop to 0 combinationally.
  - ir=00, z=0 and count=0 on the following edge.
  - After release, the first fetched word decodes normally.

Test Plan:
- Reset: hold sync_reset 2 cycles with pm_data=8'hE5 -> jmp=0, ir=8'h00, dont_jmp=0, from_ID=8'h00; release -> next edge ir=8'hE5, jmp=1, jmp_addr=4'h5.
- Load/move: pm_data=8'h3A -> reg_en=9'h008, source_sel=8. Then 8'h8A -> reg_en[1]=1, source_sel=2. Then 8'h9B (dst=src=3) -> reg_en[3]=1, source_sel=9.
- Flag then branch: 8'hC3 with r_eq_0=1, then 8'hF7 -> jmp_nz=1, jmp_addr=7, dont_jmp=1. Repeat with r_eq_0=0 -> dont_jmp=0.
- Align: z=1 from prior ALU op; pm_data=8'hD8 with r_eq_0=0 -> reg_en=0, jmp=0, jmp_nz=0; dont_jmp stays 1 next cycle.
- Mid-program reset: assert sync_reset while ir=8'hC5 -> reg_en=0 the same cycle; z=0 and from_ID=0 after the edge.
- Counter saturation: with CNT_W=8, run 300 cycles -> from_ID=8'hFF and remains there.
